// File: rtl/socket_reader.sv
// socket_reader
// Drain-side adapter for the socket FIFO. Pops words from the socket read
// port, absorbs its one-cycle registered read latency in a 2-entry buffer,
// and presents the words as a valid/ready stream with frame markers.
//
// Parameters:
//   DATA_WIDTH  word width (must match the socket)
//   FRAME_LEN   words per frame (>= 1)
// Ports:
//   i_clk         clock
//   i_rst         synchronous active-high reset
//   i_fifo_data   socket read data, valid the cycle after a granted read
//   i_fifo_empty  socket empty flag
//   o_fifo_rd_en  socket read enable (combinational)
//   o_data        stream data
//   o_valid       stream data valid
//   i_ready       downstream accepts the word
//   o_last        current word is the last of its frame
//   o_frame_cnt   completed frames, wraps modulo 2^16
module socket_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int FRAME_LEN  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
  input  logic                  i_fifo_empty,
  output logic                  o_fifo_rd_en,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_last,
  output logic [15:0]           o_frame_cnt
);

  localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);

  logic                  rd_ptr_reg;
  logic                  wr_ptr_reg;
  logic                  inflight_reg;
  logic [1:0]            count_reg;
  logic [1:0]            count_next;
  logic [IDX_W-1:0]      idx_reg;
  logic [IDX_W-1:0]      idx_next;
  logic [15:0]           frame_cnt_reg;
  logic [15:0]           frame_cnt_next;
  logic [DATA_WIDTH-1:0] slot_q [2];
  logic                  pop;

  // Two buffer slots. Data needs no reset: count gates its visibility.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      logic [DATA_WIDTH-1:0] slot_reg;
      always_ff @(posedge i_clk) begin
        if (inflight_reg && (wr_ptr_reg == 1'(gi))) begin
          slot_reg <= i_fifo_data;
        end
      end
      assign slot_q[gi] = slot_reg;
    end
  endgenerate

  assign o_valid     = (count_reg != 2'd0);
  assign o_data      = slot_q[rd_ptr_reg];
  assign o_last      = o_valid && (idx_reg == IDX_LAST);
  assign o_frame_cnt = frame_cnt_reg;
  assign pop         = o_valid && i_ready;

  // Occupancy after this edge: stored words plus the word arriving now,
  // minus the word leaving now. pop implies count >= 1, so no underflow,
  // and reads are only issued while this stays below 2, so it fits 2 bits.
  assign count_next = count_reg + {1'b0, inflight_reg} - {1'b0, pop};

  // A new read is granted only if its data will find a free slot when it
  // arrives next cycle.
  assign o_fifo_rd_en = !i_rst && !i_fifo_empty && (count_next < 2'd2);

  always_comb begin
    idx_next       = idx_reg;
    frame_cnt_next = frame_cnt_reg;
    if (pop) begin
      if (idx_reg == IDX_LAST) begin
        idx_next       = '0;
        frame_cnt_next = frame_cnt_reg + 16'd1;
      end else begin
        idx_next = idx_reg + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_reg     <= 2'd0;
      inflight_reg  <= 1'b0;
      rd_ptr_reg    <= 1'b0;
      wr_ptr_reg    <= 1'b0;
      idx_reg       <= '0;
      frame_cnt_reg <= 16'd0;
    end else begin
      count_reg     <= count_next;
      inflight_reg  <= o_fifo_rd_en;
      idx_reg       <= idx_next;
      frame_cnt_reg <= frame_cnt_next;
      if (pop) begin
        rd_ptr_reg <= !rd_ptr_reg;
      end
      if (inflight_reg) begin
        wr_ptr_reg <= !wr_ptr_reg;
      end
    end
  end

endmodule

// File: tb/tb_socket_reader.sv
// Bench for socket_reader: a behavioural socket (queue with registered read
// data) feeds the DUT; expected words are queued when pushed and compared as
// the DUT transfers them.
module tb_socket_reader;

  localparam int DW = 8;
  localparam int FL = 4;

  logic          clk = 1'b0;
  logic          i_rst = 1'b1;
  logic [DW-1:0] fifo_data = '0;
  logic          fifo_empty = 1'b1;
  logic          rd_en;
  logic [DW-1:0] o_data;
  logic          o_valid;
  logic          i_ready = 1'b0;
  logic          o_last;
  logic [15:0]   o_frame_cnt;

  logic          sock_rst = 1'b1;
  logic          push_en = 1'b0;
  logic [DW-1:0] push_data = '0;

  logic [DW-1:0] sock_q [$];
  logic [DW:0]   exp_q [$];
  int            rd_t [$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int pops = 0;
  int reads_since_pop = 0;
  int push_idx = 0;
  bit lat_mode = 0;
  bit hold_valid = 0;
  logic [DW-1:0] hold_data;
  logic          hold_last;

  socket_reader #(.DATA_WIDTH(DW), .FRAME_LEN(FL)) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_fifo_data (fifo_data),
    .i_fifo_empty(fifo_empty),
    .o_fifo_rd_en(rd_en),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_last      (o_last),
    .o_frame_cnt (o_frame_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  // Socket model: registered read data, push at the edge, empty as a flop.
  always @(posedge clk) begin
    if (sock_rst) begin
      sock_q.delete();
      fifo_empty <= 1'b1;
    end else begin
      if (rd_en && sock_q.size() > 0) fifo_data <= sock_q.pop_front();
      if (push_en) sock_q.push_back(push_data);
      fifo_empty <= (sock_q.size() == 0);
    end
  end

  // Monitor: sampled mid-cycle, a transfer happens at the next rising edge.
  always @(negedge clk) begin
    logic [DW:0] e;
    int t;
    if (i_rst) begin
      exp_q.delete();
      rd_t.delete();
      pops = 0;
      reads_since_pop = 0;
      hold_valid = 0;
    end else begin
      if (rd_en) begin
        check("rd_while_empty", fifo_empty, 0);
        rd_t.push_back(cyc);
      end
      if (hold_valid && o_valid) begin
        check("hold_data", o_data, hold_data);
        check("hold_last", o_last, hold_last);
      end
      if (o_valid && i_ready) begin
        check("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("data", o_data, e[DW-1:0]);
          check("last", o_last, e[DW]);
          $display("xfer cyc=%0d data=0x%02h last=%0b frames=%0d", cyc, o_data, o_last, o_frame_cnt);
        end
        if (rd_t.size() != 0) begin
          t = rd_t.pop_front();
          if (lat_mode) check("latency", cyc - t, 2);
        end
        pops++;
        reads_since_pop = 0;
      end else if (rd_en) begin
        reads_since_pop++;
        check("overpull", reads_since_pop <= 2, 1);
      end
      hold_valid = o_valid && !i_ready;
      hold_data  = o_data;
      hold_last  = o_last;
    end
  end

  task automatic push_word(input logic [DW-1:0] d);
    push_en   = 1'b1;
    push_data = d;
    exp_q.push_back({(push_idx == FL - 1), d});
    push_idx  = (push_idx + 1) % FL;
    @(posedge clk); #1;
    push_en   = 1'b0;
  endtask

  task automatic do_reset();
    i_rst    = 1'b1;
    sock_rst = 1'b1;
    push_en  = 1'b0;
    i_ready  = 1'b0;
    @(posedge clk); #1;
    i_rst    = 1'b0;
    sock_rst = 1'b0;
    push_idx = 0;
  endtask

  task automatic wait_drain(input int budget);
    int g = 0;
    while (exp_q.size() != 0 && g < budget) begin
      @(posedge clk); #1;
      g++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  initial begin
    int g;
    int pushed;
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int pushed;
    // Reset values with the socket holding data.
    @(posedge clk); #1;
    sock_rst  = 1'b0;
    push_en   = 1'b1;
    push_data = 8'h55;
    @(posedge clk); #1;
    push_data = 8'h66;
    @(posedge clk); #1;
    push_en   = 1'b0;
    @(negedge clk);
    check("rst_rd_en", rd_en, 0);
    check("rst_valid", o_valid, 0);
    check("rst_last", o_last, 0);
    check("rst_frame_cnt", o_frame_cnt, 0);
    @(posedge clk); #1;

    // Streaming at full rate.
    do_reset();
    lat_mode = 1;
    i_ready  = 1'b1;
    for (int i = 1; i <= 8; i++) push_word(8'(i));
    wait_drain(50);
    check("stream_frames", o_frame_cnt, 2);

    // Backpressure mid-frame.
    do_reset();
    lat_mode = 0;
    i_ready  = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      if (i == 3) i_ready = 1'b0;
      if (i == 8) i_ready = 1'b1;
      push_word(8'(i));
    end
    wait_drain(50);
    check("bp_frames", o_frame_cnt, 2);

    // Trickle input.
    do_reset();
    lat_mode = 1;
    i_ready  = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      push_word(8'(8'h10 + i));
      repeat (2) begin @(posedge clk); #1; end
    end
    wait_drain(50);
    check("trickle_frames", o_frame_cnt, 2);

    // Random traffic.
    do_reset();
    lat_mode = 0;
    pushed = 0;
    g = 0;
    while (pushed < 1000 && g < 20000) begin
      i_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) begin
        push_word(8'($urandom_range(0, 255)));
        pushed++;
      end else begin
        @(posedge clk); #1;
      end
      g++;
    end
    check("rand_pushed", pushed, 1000);
    i_ready = 1'b1;
    wait_drain(3000);
    check("rand_frames", o_frame_cnt, 250);

    // Mid-frame reset with words buffered.
    do_reset();
    lat_mode = 0;
    for (int i = 1; i <= 6; i++) push_word(8'(i));
    i_ready = 1'b1;
    g = 0;
    while (pops < 2 && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    check("mid_pop2", pops, 2);
    i_ready = 1'b0;
    @(posedge clk); #1;
    do_reset();
    @(negedge clk);
    check("mid_valid", o_valid, 0);
    check("mid_frames0", o_frame_cnt, 0);
    @(posedge clk); #1;
    i_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_word(8'(8'hA0 + i));
    wait_drain(50);
    check("mid_frames1", o_frame_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
